ad_serial_emu: RTL and testbench
================================

// Module: ad_serial_emu
// PURPOSE
//  Serial ADC responder: answers one ad_top channel master (cs_n/sclk in, sdata out) in place of the real converter.
//  Used for board bring-up and loopback of the ad->dsp->para chain.
//  Returns a programmable sample stream (constant / ramp / toggle) MSB-first, one sample per cs_n frame.
//  Configured and monitored as an fx bus slave, addressed by dev_id.
// PARAMETERS
//  DATA_W       16       sample width in bits, equal to the ad_top frame length
//  SYNC_STAGES  2        flip-flop stages used to synchronise cs_n and sclk into clk_sys
//  RST_CONST    16'h8000 reset value of the CONST register (mid-scale)
// PORTS
//  clk_sys   in   1   system clock; all logic is on this clock
//  rst_n     in   1   asynchronous, active-low reset
//  cs_n      in   1   frame select from the ad_top master; asynchronous to clk_sys
//  sclk      in   1   serial clock from the master; master samples sdata on the sclk rising edge
//  sdata     out  1   serial sample to the master, registered
//  fx_waddr  in   22  write address: [21:16] device id, [7:0] register
//  fx_wr     in   1   one-cycle write strobe
//  fx_data   in   8   write data
//  fx_rd     in   1   one-cycle read strobe
//  fx_raddr  in   22  read address, same layout as fx_waddr
//  fx_q      out  8   read data, registered; 0 unless this slave is addressed
//  dev_id    in   6   device id, tied to a constant at instantiation
// BEHAVIOUR
//  Reset outputs: sdata=0, fx_q=0, state IDLE.
//    Registers after reset: CONST=RST_CONST, STEP=1, MODE=0, EN=0; all counters 0.
//  Registers (R/W unless marked RO):
//    00 MODE[1:0]: 0 const, 1 ramp, 2 toggle (alternates CONST and ~CONST), 3 treated as 0
//    01/02 CONST lo/hi;  03/04 STEP lo/hi;  05 CTRL[0]=EN
//    06/07 FRAMES lo/hi (RO)
//    08 ABORTS (RO, 8-bit)
//    09 CLR: write any value to zero FRAMES and ABORTS
//    Unmapped registers read 0. Writes to RO registers are ignored.
//  Bus access:
//    Write takes effect the cycle after fx_wr when fx_waddr[21:16]==dev_id.
//    Read: fx_q is valid 1 cycle after fx_rd when fx_raddr[21:16]==dev_id; otherwise fx_q is 0 so the bus can OR slaves.
//    Reading FRAMES lo snapshots FRAMES hi into a shadow; a read of 07 returns the shadow.
//  Input sync and edge detect:
//    cs_n and sclk each pass through SYNC_STAGES flip-flops, then a one-register edge detector.
//    Pin-edge to sdata update latency: SYNC_STAGES+1 clk_sys cycles.
//    The master must hold sclk high and low for at least SYNC_STAGES+2 clk_sys cycles each.
//  FSM IDLE -> SHIFT -> IDLE:
//    IDLE, cs_n fall and EN=1: latch the current sample into the DATA_W shift register; sdata=MSB; bitcnt=0; go to SHIFT.
//    IDLE, cs_n fall and EN=0: stay in IDLE, sdata=0.
//    SHIFT, sclk fall: shift left; sdata = next bit; bitcnt++.
//      Once bitcnt==DATA_W-1, further falls drive sdata=0.
//    SHIFT, cs_n rise: sdata=0; go to IDLE.
//      If bitcnt>=DATA_W-1 (frame complete): FRAMES++ and advance the sample generator.
//      Otherwise: ABORTS++ and the sample is not advanced.
//  Sample generator:
//    Ramp: sample += STEP, modulo 2^DATA_W (wraps FFFF->0000).
//    Toggle: flips phase on each completed frame.
//    Entering ramp mode starts from CONST.
//    A CONST/STEP/MODE write made mid-frame applies from the next frame; the latched frame is never altered.
//  Boundaries:
//    cs_n rise and sclk fall detected in the same cycle: cs_n wins and no shift occurs.
//    EN cleared mid-frame: the current frame completes, later frames are ignored.
//    FRAMES saturates at FFFF and ABORTS at FF; CLR takes priority over an increment in the same cycle.
//    Reset mid-frame returns to IDLE immediately, with sdata=0.
//    sclk edges while in IDLE are ignored.
// STRUCTURE
//  Shared package holds:
//    register offset constants (REG_MODE..REG_CLR)
//    mode encodings
//    fx address field slices (dev id [21:16], register [7:0]), reused by other fx slaves
//  One sub-module, fx_sync_edge: SYNC_STAGES synchroniser plus rise/fall pulse outputs; instantiated for cs_n and sclk.
//  The register file, sample generator and shift FSM stay in this module.
// TESTING
//  1 EN=1, MODE=0, CONST=A5C3, one 16-sclk frame -> master captures A5C3 MSB-first; FRAMES=1; sdata=0 after cs_n rise.
//  2 MODE=1, CONST=FFFE, STEP=1, four frames -> captured FFFE, FFFF, 0000, 0001 (wrap).
//  3 Frame aborted after 9 sclk -> ABORTS=1, FRAMES unchanged; the next full frame repeats the same sample.
//  4 CONST write mid-frame -> current frame keeps the old value and the next frame carries the new one; EN=0 -> sdata stays 0, counters frozen.
//  5 Read 05 with dev_id match -> fx_q=01 one cycle after fx_rd; with a mismatched raddr -> fx_q=00; read 06 then 07 -> consistent 16-bit snapshot.
//  6 rst_n asserted mid-frame -> sdata=0 and IDLE; the following frame outputs the RST_CONST value 8000.

Source files
------------

// File: rtl/ad_serial_emu_pkg.sv
// Shared definitions for ad_serial_emu and other fx bus slaves:
// fx address layout, register offsets, sample-generator modes and FSM states.
package ad_serial_emu_pkg;

  localparam int unsigned FX_ADDR_W = 22;
  localparam int unsigned FX_DEV_W  = 6;
  localparam int unsigned FX_REG_W  = 8;
  localparam int unsigned FX_DATA_W = 8;

  // fx address layout: [21:16] device id, [15:8] unused, [7:0] register
  typedef struct packed {
    logic [FX_DEV_W-1:0] dev;
    logic [7:0]          pad;
    logic [FX_REG_W-1:0] offs;
  } fx_addr_t;

  localparam logic [FX_REG_W-1:0] REG_MODE      = 8'h00;
  localparam logic [FX_REG_W-1:0] REG_CONST_LO  = 8'h01;
  localparam logic [FX_REG_W-1:0] REG_CONST_HI  = 8'h02;
  localparam logic [FX_REG_W-1:0] REG_STEP_LO   = 8'h03;
  localparam logic [FX_REG_W-1:0] REG_STEP_HI   = 8'h04;
  localparam logic [FX_REG_W-1:0] REG_CTRL      = 8'h05;
  localparam logic [FX_REG_W-1:0] REG_FRAMES_LO = 8'h06;
  localparam logic [FX_REG_W-1:0] REG_FRAMES_HI = 8'h07;
  localparam logic [FX_REG_W-1:0] REG_ABORTS    = 8'h08;
  localparam logic [FX_REG_W-1:0] REG_CLR       = 8'h09;

  typedef enum logic [1:0] {
    MODE_CONST  = 2'd0,
    MODE_RAMP   = 2'd1,
    MODE_TOGGLE = 2'd2
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Raw MODE field to effective mode; encoding 3 behaves as constant
  function automatic mode_e eff_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_RAMP;
      2'd2:    return MODE_TOGGLE;
      default: return MODE_CONST;
    endcase
  endfunction

  function automatic logic fx_hit(input fx_addr_t a, input logic [FX_DEV_W-1:0] id);
    return a.dev == id;
  endfunction

endpackage

// File: rtl/ad_serial_emu_sync_edge.sv
// fx_sync_edge: synchronises an asynchronous level into clk and flags its edges.
//   clk, rst_n : clock, async active-low reset
//   din        : asynchronous input level
//   rise_c     : one-cycle pulse on a synchronised rising edge (combinational)
//   fall_c     : one-cycle pulse on a synchronised falling edge (combinational)
module fx_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   level;

  assign level = sync_q[SYNC_STAGES-1];

  // Synchroniser chain followed by the edge-detect history register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= level;
    end
  end

  assign rise_c = level & ~prev_q;
  assign fall_c = ~level & prev_q;

endmodule

// File: rtl/ad_serial_emu.sv
// ad_serial_emu: emulates a serial ADC for one ad_top channel master.
//   clk_sys, rst_n        : system clock, async active-low reset
//   cs_n, sclk            : frame select and serial clock from the master (async)
//   sdata                 : registered serial sample, MSB first
//   fx_waddr/fx_wr/fx_data: fx bus write port
//   fx_raddr/fx_rd/fx_q   : fx bus read port, fx_q is 0 unless addressed
//   dev_id                : this slave's fx device id
module ad_serial_emu
  import ad_serial_emu_pkg::*;
#(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RST_CONST   = 16'h8000
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic                 cs_n,
  input  logic                 sclk,
  output logic                 sdata,
  input  logic [FX_ADDR_W-1:0] fx_waddr,
  input  logic                 fx_wr,
  input  logic [FX_DATA_W-1:0] fx_data,
  input  logic                 fx_rd,
  input  logic [FX_ADDR_W-1:0] fx_raddr,
  output logic [FX_DATA_W-1:0] fx_q,
  input  logic [FX_DEV_W-1:0]  dev_id
);

  localparam int unsigned       CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  logic cs_rise, cs_fall, sclk_fall, sclk_rise_unused;

  fx_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk_sys), .rst_n(rst_n), .din(cs_n), .rise_c(cs_rise), .fall_c(cs_fall)
  );

  fx_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk_sys), .rst_n(rst_n), .din(sclk), .rise_c(sclk_rise_unused), .fall_c(sclk_fall)
  );

  fx_addr_t wa, ra;
  logic     wr_hit, rd_hit, clr_c;
  logic     unused_ok;

  assign wa     = fx_addr_t'(fx_waddr);
  assign ra     = fx_addr_t'(fx_raddr);
  assign wr_hit = fx_wr && fx_hit(wa, dev_id);
  assign rd_hit = fx_rd && fx_hit(ra, dev_id);
  assign clr_c  = wr_hit && (wa.offs == REG_CLR);
  assign unused_ok = ^{wa.pad, ra.pad, sclk_rise_unused};

  // Register file and generator state
  logic [1:0]        mode_r;
  logic [DATA_W-1:0] const_r, step_r, ramp_q;
  logic              en_r, phase_q;
  logic [15:0]       frames_q;
  logic [7:0]        aborts_q, frames_hi_shadow;
  mode_e             mode_c;
  logic [DATA_W-1:0] sample_c;

  assign mode_c = eff_mode(mode_r);

  always_comb begin
    case (mode_c)
      MODE_RAMP:   sample_c = ramp_q;
      MODE_TOGGLE: sample_c = phase_q ? ~const_r : const_r;
      default:     sample_c = const_r;
    endcase
  end

  // Shift FSM
  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic              sdata_d, done_c, abort_c;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      sdata    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      sdata    <= sdata_d;
    end
  end

  // cs_n rise is tested before sclk fall so it wins when both land together
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    sdata_d  = sdata;
    done_c   = 1'b0;
    abort_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          if (en_r) begin
            shreg_d  = sample_c;
            sdata_d  = sample_c[DATA_W-1];
            bitcnt_d = '0;
            state_d  = ST_SHIFT;
          end else begin
            sdata_d = 1'b0;
          end
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          sdata_d = 1'b0;
          state_d = ST_IDLE;
          if (bitcnt_q >= LAST_BIT) done_c  = 1'b1;
          else                      abort_c = 1'b1;
        end else if (sclk_fall) begin
          if (bitcnt_q < LAST_BIT) begin
            shreg_d  = shreg_q << 1;
            sdata_d  = shreg_q[DATA_W-2];
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end else begin
            sdata_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus writes, counters, sample generator and registered read port
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      mode_r           <= 2'd0;
      const_r          <= RST_CONST;
      step_r           <= DATA_W'(1);
      en_r             <= 1'b0;
      ramp_q           <= RST_CONST;
      phase_q          <= 1'b0;
      frames_q         <= '0;
      aborts_q         <= '0;
      frames_hi_shadow <= '0;
      fx_q             <= '0;
    end else begin
      if (wr_hit) begin
        case (wa.offs)
          REG_MODE:     mode_r  <= fx_data[1:0];
          REG_CONST_LO: const_r <= DATA_W'({const_r[DATA_W-1:8], fx_data});
          REG_CONST_HI: const_r <= DATA_W'({fx_data, const_r[7:0]});
          REG_STEP_LO:  step_r  <= DATA_W'({step_r[DATA_W-1:8], fx_data});
          REG_STEP_HI:  step_r  <= DATA_W'({fx_data, step_r[7:0]});
          REG_CTRL:     en_r    <= fx_data[0];
          default: ;
        endcase
      end

      if (clr_c) begin
        frames_q <= '0;
        aborts_q <= '0;
      end else begin
        if (done_c && frames_q != 16'hFFFF) frames_q <= frames_q + 16'd1;
        if (abort_c && aborts_q != 8'hFF)   aborts_q <= aborts_q + 8'd1;
      end

      // Outside ramp mode the accumulator follows CONST so ramps start there
      if (mode_c != MODE_RAMP) ramp_q <= const_r;
      else if (done_c)         ramp_q <= ramp_q + step_r;

      if (mode_c != MODE_TOGGLE) phase_q <= 1'b0;
      else if (done_c)           phase_q <= ~phase_q;

      fx_q <= '0;
      if (rd_hit) begin
        case (ra.offs)
          REG_MODE:      fx_q <= {6'd0, mode_r};
          REG_CONST_LO:  fx_q <= 8'(const_r);
          REG_CONST_HI:  fx_q <= 8'(const_r >> 8);
          REG_STEP_LO:   fx_q <= 8'(step_r);
          REG_STEP_HI:   fx_q <= 8'(step_r >> 8);
          REG_CTRL:      fx_q <= {7'd0, en_r};
          REG_FRAMES_LO: begin
            fx_q             <= frames_q[7:0];
            frames_hi_shadow <= frames_q[15:8];
          end
          REG_FRAMES_HI: fx_q <= frames_hi_shadow;
          REG_ABORTS:    fx_q <= aborts_q;
          default:       fx_q <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ad_serial_emu.sv
// Bench for ad_serial_emu: drives an ad_top-style master and fx bus accesses;
// expected frames and read data are queued at issue and checked by monitors.
module tb_ad_serial_emu;

  localparam logic [5:0] ID   = 6'h2A;
  localparam int         HOLD = 6;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic        cs_n    = 1'b1;
  logic        sclk    = 1'b0;
  logic        fx_wr   = 1'b0;
  logic        fx_rd   = 1'b0;
  logic [21:0] fx_waddr = '0;
  logic [21:0] fx_raddr = '0;
  logic [7:0]  fx_data  = '0;
  logic        sdata;
  logic [7:0]  fx_q;

  ad_serial_emu dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .cs_n(cs_n), .sclk(sclk), .sdata(sdata),
    .fx_waddr(fx_waddr), .fx_wr(fx_wr), .fx_data(fx_data), .fx_rd(fx_rd),
    .fx_raddr(fx_raddr), .fx_q(fx_q), .dev_id(ID)
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_frame_q[$];
  logic [7:0]  exp_rd_q[$];
  string       rd_name_q[$];
  bit          rd_pend = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic wr(input logic [7:0] r, input logic [7:0] d);
    fx_waddr = {ID, 8'h00, r};
    fx_data  = d;
    fx_wr    = 1'b1;
    cyc(1);
    fx_wr    = 1'b0;
  endtask

  task automatic rd(input logic [5:0] dev, input logic [7:0] r, input logic [7:0] e, input string nm);
    exp_rd_q.push_back(e);
    rd_name_q.push_back(nm);
    fx_raddr = {dev, 8'h00, r};
    fx_rd    = 1'b1;
    cyc(1);
    fx_rd    = 1'b0;
  endtask

  // Master frame; optional CONST write after the 5th sclk fall
  task automatic frame(input int nbits, input bit mid, input logic [7:0] lo, input logic [7:0] hi);
    cs_n = 1'b0;
    cyc(HOLD);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b1;
      cyc(HOLD);
      sclk = 1'b0;
      if (mid && i == 4) begin
        wr(8'h01, lo);
        wr(8'h02, hi);
        cyc(HOLD - 2);
      end else begin
        cyc(HOLD);
      end
    end
    cs_n = 1'b1;
    cyc(HOLD);
  endtask

  // Read monitor: fx_q is compared one cycle after each fx_rd
  initial begin
    forever begin
      @(negedge clk_sys);
      if (rd_pend) begin
        if (exp_rd_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rd_underflow: got %h expected none", fx_q);
        end else begin
          check(rd_name_q.pop_front(), {8'h00, fx_q}, {8'h00, exp_rd_q.pop_front()});
        end
      end
      rd_pend = fx_rd;
    end
  end

  // Frame monitor: captures sdata on sclk rise, checks every full 16-bit frame
  initial begin
    logic [15:0] cap;
    int          nb;
    forever begin
      @(negedge cs_n);
      cap = '0;
      nb  = 0;
      while (cs_n === 1'b0) begin
        @(posedge sclk or posedge cs_n);
        if (cs_n === 1'b0) begin
          cap = {cap[14:0], sdata};
          nb++;
        end
      end
      if (nb == 16) begin
        if (exp_frame_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL frame_underflow: got %h expected none", cap);
        end else begin
          check("frame", cap, exp_frame_q.pop_front());
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(3);
    check("rst_sdata", {15'd0, sdata}, 16'h0000);
    check("rst_fx_q", {8'h00, fx_q}, 16'h0000);
    rst_n = 1'b1;
    cyc(2);
    rd(ID, 8'h00, 8'h00, "rst_mode");
    rd(ID, 8'h01, 8'h00, "rst_const_lo");
    rd(ID, 8'h02, 8'h80, "rst_const_hi");
    rd(ID, 8'h03, 8'h01, "rst_step_lo");
    rd(ID, 8'h05, 8'h00, "rst_ctrl");
    rd(ID, 8'h06, 8'h00, "rst_frames");

    // Constant frame
    wr(8'h01, 8'hC3);
    wr(8'h02, 8'hA5);
    wr(8'h05, 8'h01);
    rd(ID, 8'h05, 8'h01, "ctrl_en");
    rd(6'h15, 8'h05, 8'h00, "ctrl_other_dev");
    exp_frame_q.push_back(16'hA5C3);
    frame(16, 1'b0, 8'h00, 8'h00);
    check("sdata_after_frame", {15'd0, sdata}, 16'h0000);
    rd(ID, 8'h06, 8'h01, "frames_1_lo");
    rd(ID, 8'h07, 8'h00, "frames_1_hi");

    // Ramp with wrap
    wr(8'h01, 8'hFE);
    wr(8'h02, 8'hFF);
    wr(8'h00, 8'h01);
    exp_frame_q.push_back(16'hFFFE);
    exp_frame_q.push_back(16'hFFFF);
    exp_frame_q.push_back(16'h0000);
    exp_frame_q.push_back(16'h0001);
    repeat (4) frame(16, 1'b0, 8'h00, 8'h00);
    rd(ID, 8'h06, 8'h05, "frames_5_lo");
    rd(ID, 8'h07, 8'h00, "frames_5_hi");

    // Aborted frame does not advance the ramp
    frame(9, 1'b0, 8'h00, 8'h00);
    rd(ID, 8'h08, 8'h01, "aborts_1");
    rd(ID, 8'h06, 8'h05, "frames_after_abort");
    exp_frame_q.push_back(16'h0002);
    frame(16, 1'b0, 8'h00, 8'h00);
    rd(ID, 8'h06, 8'h06, "frames_6");

    // Mid-frame CONST write applies to the next frame
    wr(8'h00, 8'h00);
    wr(8'h01, 8'h34);
    wr(8'h02, 8'h12);
    exp_frame_q.push_back(16'h1234);
    frame(16, 1'b1, 8'h78, 8'h56);
    exp_frame_q.push_back(16'h5678);
    frame(16, 1'b0, 8'h00, 8'h00);

    // Toggle mode
    wr(8'h00, 8'h02);
    exp_frame_q.push_back(16'h5678);
    exp_frame_q.push_back(16'hA987);
    repeat (2) frame(16, 1'b0, 8'h00, 8'h00);

    // Disabled: sdata stays 0, counters frozen, RO write ignored
    wr(8'h05, 8'h00);
    exp_frame_q.push_back(16'h0000);
    frame(16, 1'b0, 8'h00, 8'h00);
    wr(8'h06, 8'h55);
    rd(ID, 8'h06, 8'h0A, "frames_frozen");
    rd(ID, 8'h08, 8'h01, "aborts_frozen");
    rd(ID, 8'h05, 8'h00, "ctrl_dis");

    // Counter clear and unmapped register
    wr(8'h09, 8'hFF);
    rd(ID, 8'h06, 8'h00, "frames_clr");
    rd(ID, 8'h08, 8'h00, "aborts_clr");
    rd(ID, 8'h07, 8'h00, "frames_hi_clr");
    rd(ID, 8'h0A, 8'h00, "unmapped");

    // Reset mid-frame
    wr(8'h00, 8'h00);
    wr(8'h05, 8'h01);
    cs_n = 1'b0;
    cyc(HOLD);
    for (int i = 0; i < 5; i++) begin
      sclk = 1'b1;
      cyc(HOLD);
      sclk = 1'b0;
      cyc(HOLD);
    end
    rst_n = 1'b0;
    #2;
    check("sdata_in_reset", {15'd0, sdata}, 16'h0000);
    cyc(2);
    cs_n = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(HOLD);
    rd(ID, 8'h05, 8'h00, "ctrl_after_rst");
    rd(ID, 8'h02, 8'h80, "const_hi_after_rst");
    wr(8'h05, 8'h01);
    exp_frame_q.push_back(16'h8000);
    frame(16, 1'b0, 8'h00, 8'h00);
    rd(ID, 8'h06, 8'h01, "frames_after_rst");

    cyc(20);
    check("frame_q_drained", 16'(exp_frame_q.size()), 16'd0);
    check("rd_q_drained", 16'(exp_rd_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
